// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the arbitrated checkpoint register: FSM encoding
// and the pointer-width helper used by the top and the round-robin arbiter.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE         = 1'b0,
        CHECKPOINTED = 1'b1
    } fsm_state_t;

    // Width of the round-robin pointer / granted index for n requesters.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (ascending,
// wrapping) wins. Produces a one-hot grant plus the winner's index.
module rr_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int nreq  = 4,
    parameter int ptr_w = ptr_width(nreq)
) (
    input  logic [nreq-1:0]  req,
    input  logic [ptr_w-1:0] ptr,
    output logic [nreq-1:0]  grant,
    output logic [ptr_w-1:0] grant_idx
);

    // Search order: cand[k] is the requester examined k-th after ptr.
    logic [ptr_w-1:0] cand [nreq];

    genvar gi;
    generate
        for (gi = 0; gi < nreq; gi++) begin : g_cand
            assign cand[gi] = ptr_w'((int'(ptr) + gi) % nreq);
        end
    endgenerate

    // Pick the first requester in the rotated search order.
    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < nreq; k++) begin
            if (!found && req[cand[k]]) begin
                found            = 1'b1;
                grant[cand[k]]   = 1'b1;
                grant_idx        = cand[k];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared register written by nreq requesters through a round-robin arbiter,
// with a single-slot checkpoint that can be captured and reverted.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int               width = 8,
    parameter int               nreq  = 4,
    parameter logic [width-1:0] init  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [nreq-1:0]       EN,
    input  logic [nreq*width-1:0] D_IN,
    input  logic                  CHKPT,
    input  logic                  REVERT,
    output logic [nreq-1:0]       GRANT,
    output logic [width-1:0]      Q_OUT,
    output logic                  CHK_VALID
);

    localparam int ptr_w = ptr_width(nreq);

    fsm_state_t       state_reg, state_next;
    logic [width-1:0] q_reg, q_next;
    logic [width-1:0] chk_reg, chk_next;
    logic [ptr_w-1:0] ptr_reg, ptr_next;

    logic [nreq-1:0]  arb_grant;
    logic [ptr_w-1:0] arb_idx;
    logic [width-1:0] wr_data;
    logic [width-1:0] masked [nreq];

    rr_arbiter #(
        .nreq  (nreq),
        .ptr_w (ptr_w)
    ) u_rr_arbiter (
        .req       (EN),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Revert and reset both suppress any write in the current cycle.
    assign GRANT     = (RST || REVERT) ? '0 : arb_grant;
    assign Q_OUT     = q_reg;
    assign CHK_VALID = (state_reg == CHECKPOINTED);

    genvar gi;
    generate
        for (gi = 0; gi < nreq; gi++) begin : g_mask
            assign masked[gi] = D_IN[gi*width +: width] & {width{GRANT[gi]}};
        end
    endgenerate

    // One-hot grant makes an OR of masked slices a clean write-data mux.
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < nreq; k++) begin
            wr_data = wr_data | masked[k];
        end
    end

    // Next-state: revert dominates checkpoint; checkpoint sees pre-write value.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        chk_next   = chk_reg;
        ptr_next   = ptr_reg;
        if (REVERT) begin
            q_next     = (state_reg == CHECKPOINTED) ? chk_reg : init;
            state_next = IDLE;
        end else begin
            if (CHKPT) begin
                chk_next   = q_reg;
                state_next = CHECKPOINTED;
            end
            if (|GRANT) begin
                q_next   = wr_data;
                ptr_next = (int'(arb_idx) == nreq - 1) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            q_reg     <= init;
            chk_reg   <= init;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            chk_reg   <= chk_next;
            ptr_reg   <= ptr_next;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register.
module tb_shared_reg_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en;
    logic [N*W-1:0] d_in;
    logic           chkpt;
    logic           revert;
    logic [N-1:0]   grant;
    logic [W-1:0]   q_out;
    logic           chk_valid;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int       m_ptr;
    logic [7:0] m_q;
    logic [7:0] m_chk;
    bit       m_cv;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.width(W), .nreq(N), .init(8'h00)) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .D_IN      (d_in),
        .CHKPT     (chkpt),
        .REVERT    (revert),
        .GRANT     (grant),
        .Q_OUT     (q_out),
        .CHK_VALID (chk_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester that round-robin selects: first asserted at or after ptr.
    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) begin
            if (e[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock transaction, starting and ending at a falling edge.
    task automatic cycle(input string tag, input bit r, input logic [N-1:0] e,
                         input logic [N*W-1:0] d, input bit c, input bit v);
        int g;
        logic [N-1:0] exp_grant;
        rst = r; en = e; d_in = d; chkpt = c; revert = v;
        g = (r || v) ? -1 : pick(e, m_ptr);
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        #1;
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        @(posedge clk);
        if (r) begin
            m_q = 8'h00; m_chk = 8'h00; m_ptr = 0; m_cv = 0;
        end else if (v) begin
            m_q  = m_cv ? m_chk : 8'h00;
            m_cv = 0;
        end else begin
            if (c) begin
                m_chk = m_q;
                m_cv  = 1;
            end
            if (g >= 0) begin
                m_q   = d[g*W +: W];
                m_ptr = (g + 1) % N;
            end
        end
        #1;
        check({tag, ".q"},   32'(q_out),     32'(m_q));
        check({tag, ".cv"},  32'(chk_valid), 32'(m_cv));
        $display("txn %s rst=%0b en=%b chk=%0b rev=%0b grant=%b q=%0h cv=%0b",
                 tag, r, e, c, v, grant, q_out, chk_valid);
        @(negedge clk);
    endtask

    // Write a single value via requester i.
    task automatic write_one(input string tag, input int i, input logic [7:0] val);
        logic [N*W-1:0] d;
        logic [N-1:0]   e;
        d = '0; e = '0;
        d[i*W +: W] = val;
        e[i] = 1'b1;
        cycle(tag, 0, e, d, 0, 0);
    endtask

    initial begin
        logic [N*W-1:0] rr_data;
        logic [N*W-1:0] rd;
        m_ptr = 0; m_q = 0; m_chk = 0; m_cv = 0;
        rr_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held two cycles with every requester asking
        cycle("rst0", 1, 4'b1111, rr_data, 0, 0);
        cycle("rst1", 1, 4'b1111, rr_data, 0, 0);

        // Round-robin sweep 0,1,2,3
        for (int k = 0; k < 4; k++) cycle($sformatf("rr%0d", k), 0, 4'b1111, rr_data, 0, 0);

        // Move ptr to 3, then wrap-around 3 -> 0
        write_one("toptr3", 2, 8'h99);
        cycle("wrap0", 0, 4'b1001, rr_data, 0, 0);
        cycle("wrap1", 0, 4'b1001, rr_data, 0, 0);

        // Checkpoint with simultaneous write, then revert
        write_one("set5a", 0, 8'h5A);
        rd = '0; rd[1*W +: W] = 8'hC3;
        cycle("chkwr", 0, 4'b0010, rd, 1, 0);
        cycle("rev1", 0, 4'b0000, '0, 0, 1);

        // Revert with no checkpoint held goes to init
        write_one("set7e", 3, 8'h7E);
        cycle("rev0", 0, 4'b0000, '0, 0, 1);

        // Revert + checkpoint + request together in CHECKPOINTED
        write_one("set10", 1, 8'h10);
        cycle("chk10", 0, 4'b0000, '0, 1, 0);
        write_one("set20", 2, 8'h20);
        rd = '0; rd[1*W +: W] = 8'hEE;
        cycle("all3", 0, 4'b0010, rd, 1, 1);
        cycle("rev2", 0, 4'b0000, '0, 0, 1);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cycle($sformatf("rnd%0d", n),
                  ($urandom_range(0, 39) == 0),
                  N'($urandom),
                  {$urandom},
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have parameter width, default 8, data width of the shared register.
REQ-002 SHALL have parameter nreq, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter init, default all-zero width bits, reset and revert value of the register.
REQ-004 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port EN, input, nreq, per-requester write request.
REQ-007 SHALL have port D_IN, input, nreq*width, requester i data in bits [i*width+width-1 : i*width].
REQ-008 SHALL have port CHKPT, input, 1, capture the current register value as a checkpoint.
REQ-009 SHALL have port REVERT, input, 1, restore the register from the checkpoint, or to init if no checkpoint is held.
REQ-010 SHALL have port GRANT, output, nreq, one-hot or zero, combinational accept of requester write this cycle.
REQ-011 SHALL have port Q_OUT, output, width, current register value.
REQ-012 SHALL have port CHK_VALID, output, 1, checkpoint held (state CHECKPOINTED).

Function
REQ-013 SHALL grant at most one requester per cycle by round-robin, starting the search at pointer ptr and ascending with wrap from nreq-1 to 0.
REQ-014 SHALL drive GRANT to zero when EN is zero or REVERT=1.
REQ-015 SHALL set ptr to (granted index+1) mod nreq on a grant and leave it unchanged otherwise.
REQ-016 SHALL load Q_OUT with the granted requester's D_IN at the next edge (write latency 1 cycle).
REQ-017 SHALL implement a two-state FSM: IDLE -> CHECKPOINTED on CHKPT; CHECKPOINTED -> IDLE on REVERT; CHKPT in CHECKPOINTED overwrites the checkpoint and stays in CHECKPOINTED.
REQ-018 SHALL capture the pre-write Q_OUT into the checkpoint when CHKPT and a grant occur in the same cycle; the write still completes.
REQ-019 SHALL restore the checkpoint in CHECKPOINTED, or init in IDLE, on REVERT, with Q_OUT updated next cycle.
REQ-020 SHALL give REVERT priority over CHKPT when both are asserted: revert executes, the checkpoint is not updated, and the FSM moves to IDLE.
REQ-021 SHALL drop requests that are not granted; requesters hold EN until granted.
REQ-022 SHALL leave Q_OUT unchanged in a cycle with no grant and no REVERT.

Reset
REQ-023 SHALL on RST=1 at an edge set Q_OUT=init, checkpoint=init, ptr=0 and FSM=IDLE (CHK_VALID=0), overriding all other inputs in that cycle.
REQ-024 SHALL force GRANT to zero while RST=1, so an in-flight request is neither granted nor written.

Structure
REQ-025 SHALL define the FSM state encoding (IDLE=0, CHECKPOINTED=1) and the pointer width function (clog2 of nreq) in the shared package.
REQ-026 SHALL place the round-robin grant logic in one sub-module, rr_arbiter, which takes the request vector and ptr and produces a one-hot grant and the granted index.

Verification
REQ-027 SHALL cover reset: RST high 2 cycles with EN=4'b1111 -> GRANT=0 throughout; after reset Q_OUT=0 and CHK_VALID=0.
REQ-028 SHALL cover round-robin: EN=4'b1111 held for 4 cycles with D_IN values 0x11/0x22/0x33/0x44 for requesters 0..3 -> grants go 0,1,2,3 and Q_OUT reads 0x11,0x22,0x33,0x44 each one cycle later.
REQ-029 SHALL cover wrap-around: ptr=3 with EN=4'b1001 -> grant requester 3 then requester 0.
REQ-030 SHALL cover a checkpoint with a simultaneous write: Q_OUT=0x5A, then CHKPT=1 while requester 1 writes 0xC3 -> Q_OUT=0xC3 and CHK_VALID=1; then REVERT -> Q_OUT=0x5A and CHK_VALID=0.
REQ-031 SHALL cover revert without a checkpoint: Q_OUT=0x7E in IDLE, then REVERT=1 -> Q_OUT=init (0x00).
REQ-032 SHALL cover simultaneous REVERT, CHKPT and EN=4'b0010 in CHECKPOINTED with checkpoint 0x10 -> GRANT=0, Q_OUT=0x10, checkpoint unchanged, FSM goes to IDLE.
